// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encodings
// and the default operand width.
package shift_add_mul_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_add.sv
// WIDTH-bit carry-lookahead adder made of 4-bit lookahead groups; each group
// produces its internal carries and group carry-out directly from generate/propagate terms.
module cla_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NG:0]      gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = ci;

    for (genvar k = 0; k < NG; k++) begin : grp
        localparam int B = 4 * k;
        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & gc[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[k]);
        assign gc[k+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B])
                       | (p[B+3] & p[B+2] & p[B+1] & p[B] & gc[k]);
    end

    assign sum = p ^ c;
    assign co  = gc[NG];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned radix-2 shift-add multiplier: one conditional add and
// one right shift of {C,A,Q} per cycle for WIDTH cycles, then holds {A,Q}.
module shift_add_mul_ctrl
    import shift_add_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         dbg_state
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Handshake: op_start is accepted only in IDLE or DONE (not with op_clear
    // in DONE); op_done is a level held in DONE until op_clear or a new start.
    state_t           state_q, state_d;
    logic             capture, step, clear;
    logic [WIDTH-1:0] a_q, q_q, m_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] add_sum;
    logic             add_co;
    logic [WIDTH-1:0] a_next;
    logic             c_next;

    cla_add #(.WIDTH(WIDTH)) u_add (
        .a   (a_q),
        .b   (m_q),
        .ci  (1'b0),
        .sum (add_sum),
        .co  (add_co)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    capture = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                step = 1'b1;
                if (count_q == LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (op_clear) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (op_start) begin
                    capture = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The carry C exists only between the add and the shift: it is shifted
    // into the A MSB in the same cycle, so the stored C would always be zero.
    assign a_next = q_q[0] ? add_sum : a_q;
    assign c_next = q_q[0] & add_co;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
        end else if (capture) begin
            a_q     <= '0;
            q_q     <= multiplier;
            m_q     <= multiplicand;
            count_q <= '0;
        end else if (step) begin
            a_q     <= {c_next, a_next[WIDTH-1:1]};
            q_q     <= {a_next[0], q_q[WIDTH-1:1]};
            count_q <= count_q + 1'b1;
        end else if (clear) begin
            a_q <= '0;
            q_q <= '0;
        end
    end

    assign busy      = (state_q == ST_EXEC);
    assign op_done   = (state_q == ST_DONE);
    assign result    = {a_q, q_q};
    assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Bench for shift_add_mul_ctrl: WIDTH=8 table and corner sequences, random
// WIDTH=8 ops, and a WIDTH=32 random sweep against a plain a*b model.
module tb_shift_add_mul_ctrl;
    import shift_add_mul_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        start8 = 0, clear8 = 0;
    logic [7:0]  m8 = 0, q8 = 0;
    logic        busy8, done8;
    logic [15:0] result8;
    logic [1:0]  state8;

    logic        start32 = 0, clear32 = 0;
    logic [31:0] m32 = 0, q32 = 0;
    logic        busy32, done32;
    logic [63:0] result32;
    logic [1:0]  state32;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    shift_add_mul_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .op_start(start8), .op_clear(clear8),
        .multiplicand(m8), .multiplier(q8), .busy(busy8), .op_done(done8),
        .result(result8), .dbg_state(state8)
    );

    shift_add_mul_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .op_start(start32), .op_clear(clear32),
        .multiplicand(m32), .multiplier(q32), .busy(busy32), .op_done(done32),
        .result(result32), .dbg_state(state32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input bit wide);
        return wide ? done32 : done8;
    endfunction

    // Issue one op; cyc counts edges from the start-sampling edge until op_done shows.
    task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int cyc);
        if (wide) begin m32 = a; q32 = b; start32 = 1; end
        else begin m8 = a[7:0]; q8 = b[7:0]; start8 = 1; end
        tick();
        start8 = 0; start32 = 0;
        cyc = 1;
        while (!get_done(wide) && cyc < 100) begin
            tick();
            cyc++;
        end
        res = wide ? result32 : {48'd0, result8};
    endtask

    task automatic clear_op(input bit wide);
        if (wide) clear32 = 1; else clear8 = 1;
        tick();
        clear8 = 0; clear32 = 0;
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] model;
        int cyc;
        bit saw_done;
        logic [31:0] ra, rb;

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'd0};
        vecs[3] = '{8'd1,   8'd173, 16'd173};
        vecs[4] = '{8'd7,   8'd9,   16'd63};
        vecs[5] = '{8'd200, 8'd0,   16'd0};

        // Reset values
        tick(); tick();
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_result", result8, 0);
        check("rst_state", state8, ST_IDLE);
        check("rst_result32", result32, 0);
        reset = 0;
        tick();

        // op_clear in IDLE has no effect
        clear_op(0);
        check("idle_clear_state", state8, ST_IDLE);
        check("idle_clear_result", result8, 0);

        // Table vectors: latency, product, hold, clear
        foreach (vecs[i]) begin
            run_op(0, {24'd0, vecs[i].m}, {24'd0, vecs[i].q}, res, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, 9);
            check($sformatf("vec%0d_result", i), res, {48'd0, vecs[i].exp});
            tick(); tick();
            check($sformatf("vec%0d_hold", i), result8, vecs[i].exp);
            check($sformatf("vec%0d_done_hold", i), done8, 1);
            clear_op(0);
            check($sformatf("vec%0d_clr_state", i), state8, ST_IDLE);
            check($sformatf("vec%0d_clr_result", i), result8, 0);
        end

        // op_start and operand changes during EXEC are ignored
        m8 = 13; q8 = 11; start8 = 1;
        tick();
        start8 = 0; cyc = 1;
        tick(); tick(); cyc += 2;
        start8 = 1; m8 = 255; q8 = 255;
        tick(); cyc++;
        start8 = 0;
        check("exec_start_busy", busy8, 1);
        while (!done8 && cyc < 100) begin tick(); cyc++; end
        check("exec_ignore_cycles", cyc, 9);
        check("exec_ignore_result", result8, 143);

        // DONE with start and clear together: clear wins
        start8 = 1; clear8 = 1; m8 = 3; q8 = 5;
        tick();
        start8 = 0; clear8 = 0;
        check("both_state", state8, ST_IDLE);
        check("both_result", result8, 0);
        check("both_busy", busy8, 0);
        tick();
        check("both_busy_after", busy8, 0);

        // Start directly from DONE
        run_op(0, 32'd5, 32'd6, res, cyc);
        check("pre_restart_result", res, 30);
        m8 = 3; q8 = 4; start8 = 1;
        tick();
        start8 = 0;
        check("restart_busy", busy8, 1);
        check("restart_done", done8, 0);
        cyc = 1;
        while (!done8 && cyc < 100) begin tick(); cyc++; end
        check("restart_cycles", cyc, 9);
        check("restart_result", result8, 12);
        clear_op(0);

        // Reset mid-EXEC aborts the op
        m8 = 13; q8 = 11; start8 = 1;
        tick();
        start8 = 0;
        tick(); tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_result", result8, 0);
        check("abort_state", state8, ST_IDLE);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) saw_done = 1;
        end
        check("abort_no_done", saw_done, 0);
        run_op(0, 32'd7, 32'd9, res, cyc);
        check("post_abort_result", res, 63);
        check("post_abort_cycles", cyc, 9);
        clear_op(0);

        // Random WIDTH=8 ops, restarting from DONE without clearing
        for (int i = 0; i < 100; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            model = 64'(ra) * 64'(rb);
            exp_q.push_back(model);
            run_op(0, ra, rb, res, cyc);
            check("rand8_cycles", cyc, 9);
            check("rand8_result", res, exp_q.pop_front());
            if ($urandom_range(0, 1) == 1) clear_op(0);
        end

        // WIDTH=32 random sweep
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
            model = 64'(ra) * 64'(rb);
            exp_q.push_back(model);
            run_op(1, ra, rb, res, cyc);
            check("rand32_cycles", cyc, 33);
            check("rand32_result", res, exp_q.pop_front());
            clear_op(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
